// File: rtl/ui_menu_ctrl_pkg.sv
// ui_pkg: UI state and goal codes plus the button geometry shared by the menu controller and the renderer
package ui_pkg;
  typedef enum logic [3:0] {
    TITLE = 4'd0, STAFF = 4'd1, STAGE1 = 4'd2, SUCCESS1 = 4'd3, STAGE2 = 4'd4,
    SUCCESS2 = 4'd5, STAGE3 = 4'd6, SUCCESS3 = 4'd7, FAIL = 4'd8
  } ui_state_e;
  typedef enum logic [1:0] {NONE = 2'd0, FIND_KEY = 2'd1, FIND_LIGHT = 2'd2, FIND_DOOR = 2'd3} todo_e;
  localparam logic [8:0] BTN_X0 = 9'd120;
  localparam logic [8:0] BTN_X1 = 9'd200;
  localparam logic [8:0] STAGE1_Y0 = 9'd120;
  localparam logic [8:0] STAGE1_Y1 = 9'd140;
  localparam logic [8:0] STAGE2_Y0 = 9'd160;
  localparam logic [8:0] STAGE2_Y1 = 9'd180;
  localparam logic [8:0] STAGE3_Y0 = 9'd200;
  localparam logic [8:0] STAGE3_Y1 = 9'd220;
  localparam logic [8:0] NEXT_Y0 = 9'd150;
  localparam logic [8:0] NEXT_Y1 = 9'd170;
  localparam logic [8:0] RETRY_Y0 = 9'd150;
  localparam logic [8:0] RETRY_Y1 = 9'd170;
  localparam logic [8:0] BACK_Y0 = 9'd180;
  localparam logic [8:0] BACK_Y1 = 9'd200;
  localparam int BTN_STAGE1 = 0;
  localparam int BTN_STAGE2 = 1;
  localparam int BTN_STAGE3 = 2;
  localparam int BTN_NEXT = 3;
  localparam int BTN_BACK = 4;
  localparam int BTN_RETRY = 5;
  localparam int BTN_ANY = 6;
  localparam int BTN_W = 7;
  function automatic logic in_rect(input logic [8:0] x, input logic [8:0] y, input logic [8:0] x0,
                                   input logic [8:0] x1, input logic [8:0] y0, input logic [8:0] y1);
    return x >= x0 && x < x1 && y >= y0 && y < y1;
  endfunction
endpackage

// File: rtl/ui_menu_ctrl_button_hit.sv
// ui_button_hit: one-hot hit-test of a logical-coordinate click against the buttons drawn for the current state
module ui_button_hit
  import ui_pkg::*;
(
  input  logic [3:0]       state,
  input  logic [8:0]       lx,
  input  logic [8:0]       ly,
  input  logic [3:1]       play_valid,
  output logic [BTN_W-1:0] btn
);
  logic in_title, in_success, in_fail;
  assign in_title = state == TITLE;
  assign in_success = state inside {SUCCESS1, SUCCESS2, SUCCESS3};
  assign in_fail = state == FAIL;
  assign btn[BTN_STAGE1] = in_title && play_valid[1] && in_rect(lx, ly, BTN_X0, BTN_X1, STAGE1_Y0, STAGE1_Y1);
  assign btn[BTN_STAGE2] = in_title && play_valid[2] && in_rect(lx, ly, BTN_X0, BTN_X1, STAGE2_Y0, STAGE2_Y1);
  assign btn[BTN_STAGE3] = in_title && play_valid[3] && in_rect(lx, ly, BTN_X0, BTN_X1, STAGE3_Y0, STAGE3_Y1);
  assign btn[BTN_NEXT] = in_success && in_rect(lx, ly, BTN_X0, BTN_X1, NEXT_Y0, NEXT_Y1);
  assign btn[BTN_BACK] = (in_success || in_fail) && in_rect(lx, ly, BTN_X0, BTN_X1, BACK_Y0, BACK_Y1);
  assign btn[BTN_RETRY] = in_fail && in_rect(lx, ly, BTN_X0, BTN_X1, RETRY_Y0, RETRY_Y1);
  assign btn[BTN_ANY] = state == STAFF;
endmodule

// File: rtl/ui_menu_ctrl.sv
// ui_menu_ctrl: menu/stage UI state controller; defining STAGE_TIMER_EN adds a per-stage timeout and time_left
module ui_menu_ctrl
  import ui_pkg::*;
#(
  parameter int KEYS_NEEDED = 3,
  parameter int MAX_HEART = 3
`ifdef STAGE_TIMER_EN
  ,
  parameter int CLK_HZ = 100000000,
  parameter int TIME_LIMIT_S = 60
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] mouse_x,
  input  logic [9:0] mouse_y,
  input  logic       mouse_click,
  input  logic       key_got,
  input  logic       light_got,
  input  logic       door_reached,
  input  logic       hit,
  output logic [3:0] state,
  output logic [1:0] key_find,
  output logic [1:0] heart,
  output logic [1:0] todo,
  output logic [3:0] play_valid
`ifdef STAGE_TIMER_EN
  ,
  output logic [6:0] time_left
`endif
);
  ui_state_e state_q, state_d, last_stage_q, last_stage_d, click_tgt;
  todo_e todo_q, todo_d;
  logic [1:0] key_find_q, key_find_d, heart_q, heart_d;
  logic [3:0] play_valid_q, play_valid_d;
  logic click_prev_q, click_prev_d, pending_q, pending_d;
  logic [8:0] lx_q, lx_d, ly_q, ly_d;
  logic [BTN_W-1:0] btn;
  logic in_stage, door_ok, timeout;
`ifdef STAGE_TIMER_EN
  localparam int PW = $clog2(CLK_HZ);
  logic [PW-1:0] presc_q, presc_d;
  logic [6:0] time_left_q, time_left_d;
  assign time_left = time_left_q;
`endif
  assign in_stage = state_q inside {STAGE1, STAGE2, STAGE3};
  assign state = state_q;
  assign key_find = key_find_q;
  assign heart = heart_q;
  assign todo = todo_q;
  assign play_valid = play_valid_q;
  ui_button_hit u_hit (
    .state(state_q),
    .lx(lx_q),
    .ly(ly_q),
    .play_valid(play_valid_q[3:1]),
    .btn(btn)
  );
  always_comb begin
    click_tgt = state_q;
    if (btn[BTN_STAGE1]) click_tgt = STAGE1;
    if (btn[BTN_STAGE2]) click_tgt = STAGE2;
    if (btn[BTN_STAGE3]) click_tgt = STAGE3;
    if (btn[BTN_NEXT]) begin
      if (state_q == SUCCESS1) click_tgt = STAGE2;
      else if (state_q == SUCCESS2) click_tgt = STAGE3;
      else click_tgt = STAFF;
    end
    if (btn[BTN_RETRY]) click_tgt = last_stage_q;
    if (btn[BTN_BACK] || btn[BTN_ANY]) click_tgt = TITLE;
  end
  always_comb begin
    state_d = state_q;
    last_stage_d = last_stage_q;
    todo_d = todo_q;
    key_find_d = key_find_q;
    heart_d = heart_q;
    play_valid_d = play_valid_q;
    click_prev_d = mouse_click;
    pending_d = mouse_click && !click_prev_q;
    lx_d = pending_d ? 9'(mouse_x >> 1) : lx_q;
    ly_d = pending_d ? 9'(mouse_y >> 1) : ly_q;
    door_ok = in_stage && door_reached && todo_q == FIND_DOOR;
`ifdef STAGE_TIMER_EN
    presc_d = presc_q;
    time_left_d = time_left_q;
    if (in_stage) begin
      presc_d = presc_q == PW'(CLK_HZ - 1) ? '0 : presc_q + PW'(1);
      if (presc_q == PW'(CLK_HZ - 1) && time_left_q != 7'd0) time_left_d = time_left_q - 7'd1;
    end
    timeout = in_stage && time_left_q == 7'd0;
`else
    timeout = 1'b0;
`endif
    if (in_stage) begin
      if (light_got && todo_q == FIND_LIGHT) todo_d = FIND_KEY;
      if (key_got && todo_q == FIND_KEY) begin
        key_find_d = key_find_q + 2'd1;
        if (key_find_d == 2'(KEYS_NEEDED)) todo_d = FIND_DOOR;
      end
      if (hit && heart_q != 2'd0) heart_d = heart_q - 2'd1;
      if (door_ok) begin
        todo_d = NONE;
        if (state_q == STAGE1) begin
          state_d = SUCCESS1;
          play_valid_d[2] = 1'b1;
        end else if (state_q == STAGE2) begin
          state_d = SUCCESS2;
          play_valid_d[3] = 1'b1;
        end else state_d = SUCCESS3;
      end else if ((hit && heart_d == 2'd0) || timeout) begin
        state_d = FAIL;
        todo_d = NONE;
      end
    end else if (pending_q && click_tgt != state_q) begin
      state_d = click_tgt;
      if (click_tgt inside {STAGE1, STAGE2, STAGE3}) begin
        heart_d = 2'(MAX_HEART);
        key_find_d = 2'd0;
        last_stage_d = click_tgt;
        todo_d = click_tgt == STAGE1 ? FIND_KEY : FIND_LIGHT;
`ifdef STAGE_TIMER_EN
        presc_d = '0;
        time_left_d = 7'(TIME_LIMIT_S);
`endif
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TITLE;
      last_stage_q <= STAGE1;
      todo_q <= NONE;
      key_find_q <= 2'd0;
      heart_q <= 2'(MAX_HEART);
      play_valid_q <= 4'b0010;
      click_prev_q <= 1'b0;
      pending_q <= 1'b0;
      lx_q <= '0;
      ly_q <= '0;
    end else begin
      state_q <= state_d;
      last_stage_q <= last_stage_d;
      todo_q <= todo_d;
      key_find_q <= key_find_d;
      heart_q <= heart_d;
      play_valid_q <= play_valid_d;
      click_prev_q <= click_prev_d;
      pending_q <= pending_d;
      lx_q <= lx_d;
      ly_q <= ly_d;
    end
  end
`ifdef STAGE_TIMER_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      time_left_q <= 7'(TIME_LIMIT_S);
    end else begin
      presc_q <= presc_d;
      time_left_q <= time_left_d;
    end
  end
`endif
endmodule

// File: doc/ui_menu_ctrl.md
Name: ui_menu_ctrl

Overview:
- Game/menu controller that produces the UI state vector consumed by the interface renderer: state, key_find, heart, todo, play_valid.
- Hit-tests mouse clicks against the on-screen button rectangles the renderer draws, in 320x240 logical coordinates.
- Sequences the stage gameplay goals from game-logic event pulses, and unlocks later stages.
- Sits between the mouse/game-logic blocks and the renderer.

Parameters:
KEYS_NEEDED, 3, keys required before todo becomes FIND_DOOR (1..3)
MAX_HEART, 3, lives loaded on stage entry (1..3)
CLK_HZ, 100000000, clock frequency; used only with STAGE_TIMER_EN
TIME_LIMIT_S, 60, per-stage time limit in seconds; used only with STAGE_TIMER_EN

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
mouse_x  in  10  pointer x in 640-wide screen pixels
mouse_y  in  10  pointer y in 480-high screen pixels
mouse_click  in  1  left button level
key_got  in  1  1-cycle pulse: key collected
light_got  in  1  1-cycle pulse: light collected
door_reached  in  1  1-cycle pulse: player at door
hit  in  1  1-cycle pulse: player damaged
state  out  4  UI state code
key_find  out  2  keys collected this stage
heart  out  2  lives remaining
todo  out  2  current goal code
play_valid  out  4  stage unlock mask; bit k means stage k is playable; bit0 is always 0

Behaviour:
- Reset values: state=TITLE, key_find=0, heart=MAX_HEART, todo=NONE, play_valid=4'b0010, last_stage=STAGE1, internal click_prev=0, pending=0.
- Click path:
  - Logical coordinates: lx=mouse_x>>1, ly=mouse_y>>1.
  - Rise condition: at clock edge N, mouse_click=1 and click_prev=0. On that edge the block latches lx/ly and sets pending.
  - At edge N+1 the hit-test runs on the latched coordinates, state updates, and pending clears.
  - A held button produces one action only.
- Button rectangles (inclusive low, exclusive high):
  - TITLE: stage1 x120-200, y120-140. stage2 x120-200, y160-180; acts only if play_valid[2]. stage3 x120-200, y200-220; acts only if play_valid[3]. Clicks on a locked button are ignored.
  - SUCCESSk: next x120-200, y150-170. back x120-200, y180-200.
  - FAIL: retry x120-200, y150-170. back x120-200, y180-200.
  - STAFF: a click anywhere returns to TITLE.
  - STAGEk: clicks are ignored.
- State transitions:
  - TITLE button k -> STAGEk.
  - SUCCESS1 next -> STAGE2; SUCCESS2 next -> STAGE3; SUCCESS3 next -> STAFF.
  - Any back -> TITLE.
  - FAIL retry -> last_stage.
- Stage entry, same edge as the transition:
  - heart=MAX_HEART, key_find=0, last_stage=target stage.
  - todo=FIND_KEY for STAGE1; FIND_LIGHT for STAGE2/3.
- Leaving stage states:
  - On exit to a non-STAGE state, todo=NONE.
  - key_find and heart hold their values.
- Events: honoured only in STAGE states, ignored elsewhere.
  - light_got: if todo==FIND_LIGHT -> FIND_KEY.
  - key_got: if todo==FIND_KEY, key_find increments. On reaching KEYS_NEEDED, todo=FIND_DOOR in the same edge.
  - door_reached: if todo==FIND_DOOR -> SUCCESSk.
  - hit: heart decrements, saturating at 0. heart reaching 0 -> FAIL.
- Simultaneous events:
  - door_reached (valid) and a fatal hit in the same cycle: SUCCESS wins.
  - key_got and hit in the same cycle: both applied.
  - Unlock on SUCCESS1 sets play_valid[2]; unlock on SUCCESS2 sets play_valid[3]. play_valid is sticky until rst.
- rst during any state or with pending set: all reset values apply on that edge; pending is dropped.

Optional Feature:
STAGE_TIMER_EN.
- Defined:
  - Adds output time_left[6:0], loaded with TIME_LIMIT_S on stage entry.
  - A CLK_HZ-cycle prescaler decrements time_left once per second while in a STAGE state.
  - time_left==0 -> FAIL. door_reached has priority in the same cycle.
  - time_left resets to TIME_LIMIT_S.
- Undefined: no port, no counter, no timeout.

Decomposition:
- Package ui_pkg holds:
  - state codes: TITLE=0, STAFF=1, STAGE1=2, SUCCESS1=3, STAGE2=4, SUCCESS2=5, STAGE3=6, SUCCESS3=7, FAIL=8
  - todo codes: NONE=0, FIND_KEY=1, FIND_LIGHT=2, FIND_DOOR=3
  - all button rectangle bounds, shared with the renderer
- Sub-module ui_button_hit: combinational. Takes state, lx, ly, play_valid and returns a one-hot button hit (stage1/2/3, next, back, retry, any).

Test Plan:
- rst, click at (260,260) -> 2 edges after the rise, state=2, heart=3, todo=1, key_find=0.
- In STAGE1, 3 key_got pulses then door_reached -> key_find=3, todo=3, state=3, play_valid=4'b0110.
- TITLE click at (260,340) before unlock -> state stays 0. After SUCCESS1, back (260,380) then (260,340) -> state=4, todo=2.
- STAGE2, 3 hit pulses -> heart 2,1,0 and state=8. Retry (260,320) -> state=4, heart=3.
- mouse_click held high 100 cycles in TITLE over stage1 -> exactly one transition. Fatal hit plus door_reached in the same cycle with todo=3 -> SUCCESS.
- STAGE_TIMER_EN with CLK_HZ=10, TIME_LIMIT_S=2: enter STAGE1, idle 20 cycles -> state=8. rst mid-stage -> state=0, play_valid=4'b0010.
